weight_pair_fetch: RTL and testbench

- Downstream neighbour of the weight address generator. It takes the registered addra/addrb pair each cycle and drives them to the dual-port weight ROM.
- Aligns the returned weight pair with the ROM read latency, buffers it in a small FIFO, and presents it to the MAC array with a valid/ready handshake.
- Tags the last pair of each output pixel so the MAC can flush its accumulator.
- Asserts `stall` so the controller can drop the address generator's enable before the FIFO overflows.

---
 rtl/weight_pair_fetch_pkg.sv | 26 ++
 rtl/weight_pair_fifo.sv | 66 ++++++
 rtl/weight_pair_fetch.sv | 120 ++++++++++++
 tb/tb_weight_pair_fetch.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pair_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_pair_fetch_pkg                                                |
// | Network-wide weight-path constants shared by the fetch block.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package weight_pair_fetch_pkg;

  localparam int WEIGHT_ADDR_WIDTH   = 10;
  localparam int WEIGHT_WIDTH        = 16;
  localparam int NUM_ONE_PIXEL_CYCLE = 13;
  localparam int PAIR_CNT_BITWIDTH   = 4;
  localparam int FIFO_DEPTH          = 8;

  // One FIFO entry carries {last, weight_a, weight_b}.
  function automatic int pair_width(input int weight_width);
    return 2 * weight_width + 1;
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_pair_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_pair_fifo                                                     |
// | First-word fall-through FIFO with occupancy and drop indication.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module weight_pair_fifo
  import weight_pair_fetch_pkg::*;
#(
  parameter int WIDTH = pair_width(WEIGHT_WIDTH),
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          drop
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = count_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign w_full = (r_count == c_cw'(DEPTH));
  assign w_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push = wr_en && (!w_full || w_pop);
  assign drop   = wr_en && !w_push;
  assign count  = r_count;
  // Masked so the head reads as zero whenever nothing is buffered.
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/weight_pair_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_pair_fetch                                                    |
// | Drives the weight ROM, realigns returned pairs, buffers them for the |
// | MAC array and tags the last pair of every output pixel.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module weight_pair_fetch
  import weight_pair_fetch_pkg::*;
#(
  parameter int WEIGHT_ADDR_WIDTH   = weight_pair_fetch_pkg::WEIGHT_ADDR_WIDTH,
  parameter int WEIGHT_WIDTH        = weight_pair_fetch_pkg::WEIGHT_WIDTH,
  parameter int NUM_ONE_PIXEL_CYCLE = weight_pair_fetch_pkg::NUM_ONE_PIXEL_CYCLE,
  parameter int PAIR_CNT_BITWIDTH   = weight_pair_fetch_pkg::PAIR_CNT_BITWIDTH,
  parameter int ROM_LATENCY         = 1,
  parameter int FIFO_DEPTH          = weight_pair_fetch_pkg::FIFO_DEPTH,
  parameter int SKID                = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         addr_valid,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] addra,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] addrb,
  output logic [WEIGHT_ADDR_WIDTH-1:0] rom_addra,
  output logic [WEIGHT_ADDR_WIDTH-1:0] rom_addrb,
  input  logic [WEIGHT_WIDTH-1:0]      rom_douta,
  input  logic [WEIGHT_WIDTH-1:0]      rom_doutb,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic [WEIGHT_WIDTH-1:0]      w_a,
  output logic [WEIGHT_WIDTH-1:0]      w_b,
  output logic                         w_last,
  output logic                         stall,
  output logic                         overflow
);

  localparam int         c_pair_w       = pair_width(WEIGHT_WIDTH);
  localparam int         c_cnt_w        = count_width(FIFO_DEPTH);
  localparam logic [7:0] c_stall_thresh = 8'(FIFO_DEPTH - SKID);

  logic [PAIR_CNT_BITWIDTH-1:0] r_pair_cnt;
  logic                         w_pair_last;
  logic [ROM_LATENCY-1:0]       r_pipe_valid;
  logic [ROM_LATENCY-1:0]       r_pipe_last;
  logic                         w_fifo_wr;
  logic [c_pair_w-1:0]          w_fifo_din;
  logic [c_pair_w-1:0]          w_fifo_head;
  logic                         w_fifo_empty;
  logic [c_cnt_w-1:0]           w_fifo_count;
  logic                         w_fifo_drop;
  logic [7:0]                   w_inflight;
  logic [7:0]                   w_fill;
  logic                         r_stall;
  logic                         r_overflow;

  // The ROM registers its own address, so no extra stage here.
  assign rom_addra = addra;
  assign rom_addrb = addrb;

  assign w_pair_last = (r_pair_cnt == PAIR_CNT_BITWIDTH'(NUM_ONE_PIXEL_CYCLE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pair_cnt <= '0;
    end else if (addr_valid) begin
      r_pair_cnt <= w_pair_last ? '0 : r_pair_cnt + PAIR_CNT_BITWIDTH'(1);
    end
  end

  // Valid/last travel alongside the ROM read so data and tag meet at the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe_valid <= '0;
      r_pipe_last  <= '0;
    end else begin
      r_pipe_valid <= (r_pipe_valid << 1) | ROM_LATENCY'(addr_valid);
      r_pipe_last  <= (r_pipe_last << 1)  | ROM_LATENCY'(addr_valid && w_pair_last);
    end
  end

  assign w_fifo_wr  = r_pipe_valid[ROM_LATENCY-1];
  assign w_fifo_din = {r_pipe_last[ROM_LATENCY-1], rom_douta, rom_doutb};

  weight_pair_fifo #(
    .WIDTH (c_pair_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_fifo_wr),
    .wr_data (w_fifo_din),
    .rd_en   (w_ready),
    .rd_data (w_fifo_head),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count),
    .drop    (w_fifo_drop)
  );

  assign w_valid               = !w_fifo_empty;
  assign {w_last, w_a, w_b}    = w_fifo_head;

  // Count buffered, in-flight and just-issued pairs so stall leaves SKID slots free.
  assign w_inflight = 8'($countones(r_pipe_valid));
  assign w_fill     = 8'(w_fifo_count) + w_inflight + 8'(addr_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_stall <= (w_fill >= c_stall_thresh);
      if (w_fifo_drop) r_overflow <= 1'b1;
    end
  end

  assign stall    = r_stall;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_weight_pair_fetch.sv
`default_nettype none
// Self-checking bench for weight_pair_fetch: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_weight_pair_fetch;

  localparam int AW    = 10;
  localparam int WW    = 16;
  localparam int DEPTH = 8;
  localparam int LAT   = 1;
  localparam int NPIX  = 13;
  localparam int SKID  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          addr_valid = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [AW-1:0] addrb = '0;
  logic [AW-1:0] rom_addra;
  logic [AW-1:0] rom_addrb;
  logic [WW-1:0] rom_douta;
  logic [WW-1:0] rom_doutb;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [WW-1:0] w_a;
  logic [WW-1:0] w_b;
  logic          w_last;
  logic          stall;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  weight_pair_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .addr_valid (addr_valid),
    .addra      (addra),
    .addrb      (addrb),
    .rom_addra  (rom_addra),
    .rom_addrb  (rom_addrb),
    .rom_douta  (rom_douta),
    .rom_doutb  (rom_doutb),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_a        (w_a),
    .w_b        (w_b),
    .w_last     (w_last),
    .stall      (stall),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // ROM model: one cycle latency, data equals address.
  always @(posedge clk) begin
    rom_douta <= WW'(rom_addra);
    rom_doutb <= WW'(rom_addrb);
  end

  // Behavioural model: issued pairs wait LAT edges, then enter a bounded queue.
  typedef struct {
    logic [2*WW:0] d;
    int            due;
  } pend_t;

  logic [2*WW:0] m_fifo[$];
  pend_t         m_pend[$];
  int            m_cyc = 0;
  int            m_pcnt = 0;
  bit            m_stall = 1'b0;
  bit            m_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    int    sz;
    bit    pop;
    bit    stall_n;
    pend_t p;
    if (reset) begin
      m_fifo.delete();
      m_pend.delete();
      m_pcnt  = 0;
      m_stall = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      sz      = m_fifo.size();
      stall_n = (sz + m_pend.size() + int'(addr_valid)) >= (DEPTH - SKID);
      pop     = (sz > 0) && w_ready;
      if (pop) void'(m_fifo.pop_front());
      if (m_pend.size() > 0 && m_pend[0].due == m_cyc) begin
        if (sz < DEPTH || pop) m_fifo.push_back(m_pend[0].d);
        else m_ovf = 1'b1;
        void'(m_pend.pop_front());
      end
      if (addr_valid) begin
        p.d   = {(m_pcnt == NPIX - 1), WW'(addra), WW'(addrb)};
        p.due = m_cyc + LAT;
        m_pend.push_back(p);
        m_pcnt = (m_pcnt + 1) % NPIX;
      end
      m_stall = stall_n;
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; addr_valid = 1'b0; w_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; addr_valid = 1'b0; w_ready = 1'b0; addra = '0; addrb = '0;
    repeat (3) tick();
    n_checks++;
    if (w_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_hold_valid: got %b want 0", w_valid);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({w_valid, w_last, stall, overflow} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags: got %b want 0000", {w_valid, w_last, stall, overflow});
    end
    n_checks++;
    if (w_a !== '0 || w_b !== '0) begin
      n_errors++; $display("FAIL reset_data: got %h/%h want 0/0", w_a, w_b);
    end
  endtask

  task automatic test_streaming();
    int got = 0;
    int first_valid = -1;
    bit stall_seen = 1'b0;
    w_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < NPIX) begin
        addr_valid = 1'b1; addra = AW'(2 * c); addrb = AW'(2 * c + 1);
      end else begin
        addr_valid = 1'b0;
      end
      if (stall) stall_seen = 1'b1;
      if (w_valid) begin
        if (first_valid < 0) first_valid = c;
        n_checks++;
        if (w_a !== WW'(2 * got) || w_b !== WW'(2 * got + 1) || w_last !== (got == NPIX - 1)) begin
          n_errors++;
          $display("FAIL stream_pair%0d: got %0d/%0d last=%b want %0d/%0d last=%b",
                   got, w_a, w_b, w_last, 2 * got, 2 * got + 1, (got == NPIX - 1));
        end
        got++;
      end
      tick();
    end
    addr_valid = 1'b0;
    n_checks++;
    if (first_valid !== 2) begin
      n_errors++; $display("FAIL stream_latency: got %0d want 2", first_valid);
    end
    n_checks++;
    if (got !== NPIX) begin
      n_errors++; $display("FAIL stream_count: got %0d want %0d", got, NPIX);
    end
    n_checks++;
    if (stall_seen !== 1'b0) begin
      n_errors++; $display("FAIL stream_stall: got %b want 0", stall_seen);
    end
  endtask

  task automatic test_backpressure();
    int sc = 0;
    int issued = 0;
    int rise = -1;
    int got = 0;
    do_reset();
    w_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (stall) begin
        sc++;
        if (rise < 0) rise = c;
      end
      addr_valid = (sc <= SKID);
      if (addr_valid) begin
        addra = AW'(100 + 2 * issued); addrb = AW'(101 + 2 * issued);
        issued++;
      end
      tick();
    end
    addr_valid = 1'b0;
    n_checks++;
    if (rise !== 6) begin
      n_errors++; $display("FAIL bp_stall_rise: got cycle %0d want 6", rise);
    end
    n_checks++;
    if ({stall, overflow, w_valid} !== 3'b101) begin
      n_errors++; $display("FAIL bp_full_flags: got stall/ovf/valid=%b want 101", {stall, overflow, w_valid});
    end
    w_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (w_valid) begin
        n_checks++;
        if (w_a !== WW'(100 + 2 * got) || w_b !== WW'(101 + 2 * got) || w_last !== 1'b0) begin
          n_errors++;
          $display("FAIL bp_drain%0d: got %0d/%0d last=%b want %0d/%0d last=0",
                   got, w_a, w_b, w_last, 100 + 2 * got, 101 + 2 * got);
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got !== DEPTH || issued !== DEPTH) begin
      n_errors++; $display("FAIL bp_entries: got drained=%0d issued=%0d want %0d", got, issued, DEPTH);
    end
    n_checks++;
    if ({stall, overflow} !== 2'b00) begin
      n_errors++; $display("FAIL bp_after_drain: got stall/ovf=%b want 00", {stall, overflow});
    end
  endtask

  task automatic test_overflow();
    int got = 0;
    do_reset();
    w_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      addr_valid = 1'b1; addra = AW'(200 + 2 * c); addrb = AW'(201 + 2 * c);
      tick();
    end
    addr_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++; $display("FAIL ovf_set: got %b want 1", overflow);
    end
    w_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (w_valid) begin
        n_checks++;
        if (w_a !== WW'(200 + 2 * got) || w_b !== WW'(201 + 2 * got)) begin
          n_errors++;
          $display("FAIL ovf_kept%0d: got %0d/%0d want %0d/%0d", got, w_a, w_b, 200 + 2 * got, 201 + 2 * got);
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got !== DEPTH) begin
      n_errors++; $display("FAIL ovf_kept_count: got %0d want %0d", got, DEPTH);
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++; $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    do_reset();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++; $display("FAIL ovf_cleared: got %b want 0", overflow);
    end
  endtask

  task automatic test_full_pushpop();
    int got = 0;
    bit stall_mid = 1'b0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      addr_valid = (c < 18);
      addra = AW'(300 + 2 * c); addrb = AW'(301 + 2 * c);
      w_ready = (c >= 9);
      if (c == 15) stall_mid = stall;
      if (w_valid && w_ready) begin
        n_checks++;
        if (w_a !== WW'(300 + 2 * got) || w_b !== WW'(301 + 2 * got) || w_last !== (got == NPIX - 1)) begin
          n_errors++;
          $display("FAIL full_pp%0d: got %0d/%0d last=%b want %0d/%0d last=%b",
                   got, w_a, w_b, w_last, 300 + 2 * got, 301 + 2 * got, (got == NPIX - 1));
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got !== 18) begin
      n_errors++; $display("FAIL full_pp_count: got %0d want 18", got);
    end
    n_checks++;
    if ({stall_mid, overflow} !== 2'b10) begin
      n_errors++; $display("FAIL full_pp_flags: got stall/ovf=%b want 10", {stall_mid, overflow});
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    do_reset();
    w_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      addr_valid = 1'b1; addra = AW'(400 + 2 * c); addrb = AW'(401 + 2 * c);
      tick();
    end
    addr_valid = 1'b0;
    n_checks++;
    if (w_valid !== 1'b1 || w_a !== WW'(400)) begin
      n_errors++; $display("FAIL rmid_pre: got valid=%b a=%0d want 1/400", w_valid, w_a);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (w_valid !== 1'b0 || w_a !== '0) begin
      n_errors++; $display("FAIL rmid_async: got valid=%b a=%0d want 0/0", w_valid, w_a);
    end
    #1;
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (w_valid !== 1'b0) begin
      n_errors++; $display("FAIL rmid_late_data: got valid=%b want 0", w_valid);
    end
    w_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      addr_valid = (c < NPIX);
      addra = AW'(500 + 2 * c); addrb = AW'(501 + 2 * c);
      if (w_valid) begin
        n_checks++;
        if (w_a !== WW'(500 + 2 * got) || w_last !== (got == NPIX - 1)) begin
          n_errors++;
          $display("FAIL rmid_pair%0d: got %0d last=%b want %0d last=%b",
                   got, w_a, w_last, 500 + 2 * got, (got == NPIX - 1));
        end
        got++;
      end
      tick();
    end
    addr_valid = 1'b0;
    n_checks++;
    if (got !== NPIX) begin
      n_errors++; $display("FAIL rmid_count: got %0d want %0d", got, NPIX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      w_ready    = ($urandom_range(0, 99) < (((c / 100) % 2) != 0 ? 20 : 85));
      addr_valid = !stall && ($urandom_range(0, 3) != 0);
      addra      = AW'($urandom);
      addrb      = AW'($urandom);
      n_checks++;
      if (w_valid !== (m_fifo.size() != 0)) begin
        n_errors++; $display("FAIL rand_valid@%0d: got %b want %b", c, w_valid, (m_fifo.size() != 0));
      end
      if (m_fifo.size() != 0) begin
        n_checks++;
        if ({w_last, w_a, w_b} !== m_fifo[0]) begin
          n_errors++; $display("FAIL rand_head@%0d: got %h want %h", c, {w_last, w_a, w_b}, m_fifo[0]);
        end
      end
      n_checks++;
      if (stall !== m_stall || overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL rand_flags@%0d: got stall/ovf=%b%b want %b%b", c, stall, overflow, m_stall, m_ovf);
      end
      tick();
    end
    addr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
